gate_cursor_ctrl: RTL
=====================

GATE_CURSOR_CTRL -- requirements
Module: gate_cursor_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 8: grid columns; legal range >= 2.
REQ-002 SHALL have parameter ROWS, default 3: grid rows; legal range >= 1.
REQ-003 SHALL have parameter DB_CYCLES, default 1000000: debounce stability window in clocks; legal range >= 1.
REQ-004 SHALL have parameter REPEAT_DELAY, default 50000000: clocks from press to first auto-repeat; 0 disables auto-repeat.
REQ-005 SHALL have parameter REPEAT_PERIOD, default 15000000: clocks between auto-repeats; legal range >= 1.
REQ-006 SHALL have parameter VWRAP, default 0: 0 = clamp vertical moves, 1 = wrap vertical moves.
REQ-007 SHALL have port clock, input, 1: the single clock for all logic.
REQ-008 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-009 SHALL have ports btn_l, btn_r, btn_u, btn_d, btn_c, input, 1 each: raw asynchronous push-buttons (left, right, up, down, centre/select).
REQ-010 SHALL have port cursor_col, output, $clog2(COLS): current column, 0 = leftmost.
REQ-011 SHALL have port cursor_row, output, max(1,$clog2(ROWS)): current row, 0 = top.
REQ-012 SHALL have port cursor_index, output, $clog2(COLS*ROWS+1): 1-based index, row*COLS + col + 1.
REQ-013 SHALL have port moved, output, 1: one-cycle pulse when cursor changes.
REQ-014 SHALL have port select_pulse, output, 1: one-cycle pulse on a debounced btn_c press.
REQ-015 SHALL have port select_index, output, same width as cursor_index: index captured at the last select.

Function
REQ-016 SHALL pass each button through a 2-flop synchroniser before any other use.
REQ-017 SHALL keep a per-button debounced state, updated only after the synchronised input differs from it for DB_CYCLES consecutive clocks; any sample equal to the debounced state clears that button's counter.
REQ-018 SHALL generate a one-cycle press event on each debounced 0->1 transition; 1->0 generates nothing.
REQ-019 SHALL, for l/r/u/d only and when REPEAT_DELAY > 0, generate a repeat event REPEAT_DELAY clocks after the press event and every REPEAT_PERIOD clocks thereafter while the debounced state stays 1; release stops repeats immediately.
REQ-020 SHALL apply at most one move per clock; priority l > r > u > d; lower-priority events that cycle are discarded, not queued.
REQ-021 SHALL treat horizontal moves as wrapping within the row: col 0 left -> COLS-1, col COLS-1 right -> 0; row unchanged.
REQ-022 SHALL, with VWRAP=0, ignore up at row 0 and down at row ROWS-1 (no change, no moved pulse); with VWRAP=1, wrap row 0 <-> ROWS-1.
REQ-023 SHALL update cursor registers on the edge following the event; moved SHALL assert in the first cycle the new value is visible.
REQ-024 SHALL give an end-to-end latency of exactly DB_CYCLES+3 clocks from the first edge sampling a stable raw 1 to the visible cursor change.
REQ-025 SHALL assert select_pulse with the same latency as a move and load select_index in that same cycle; a select coinciding with a move captures the pre-move index.
REQ-026 SHALL never produce cursor_col >= COLS or cursor_row >= ROWS.

Reset
REQ-027 SHALL, while reset is high at a clock edge, set cursor_col=0, cursor_row=0, cursor_index=1, select_index=1, moved=0, select_pulse=0, and clear all synchroniser flops, debounced states, debounce counters and repeat counters.
REQ-028 SHALL, for a button held through reset release, treat it as a fresh press (debounced state restarts at 0).
REQ-029 SHALL let reset asserted mid-debounce or mid-repeat discard that activity with no pulse emitted.

Verification (COLS=8, ROWS=3, DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-030 SHALL cover: reset -> index 1, col 0, row 0, moved 0, select_pulse 0.
REQ-031 SHALL cover: btn_r high 3 clocks -> no change; btn_r held -> col 1, index 2, moved pulse exactly 7 clocks after first high sample.
REQ-032 SHALL cover: at col 7 row 1 press r -> col 0 row 1 index 9; press l -> col 7 index 16.
REQ-033 SHALL cover: at row 2 press d -> VWRAP=0 no change, moved 0; VWRAP=1 -> row 0.
REQ-034 SHALL cover: btn_r held 30 clocks from col 0 -> moves at clocks 7, 17, 20, 23, 26, 29; final col 6.
REQ-035 SHALL cover: btn_l and btn_r pressed simultaneously at col 3 -> col 2 only; btn_c with btn_d at index 4 -> select_index 4, row 1.

Source files
------------

// File: rtl/gate_cursor_ctrl.sv
// Grid cursor driven by five debounced push-buttons, with auto-repeat on the arrow keys.
// Latency DB_CYCLES+3 clocks from a stable raw press to the cursor change; no backpressure.
module gate_cursor_ctrl #(
    parameter int COLS          = 8,
    parameter int ROWS          = 3,
    parameter int DB_CYCLES     = 1000000,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 15000000,
    parameter int VWRAP         = 0
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     btn_l,
    input  logic                                     btn_r,
    input  logic                                     btn_u,
    input  logic                                     btn_d,
    input  logic                                     btn_c,
    output logic [$clog2(COLS)-1:0]                  cursor_col,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] cursor_row,
    output logic [$clog2(COLS*ROWS+1)-1:0]           cursor_index,
    output logic                                     moved,
    output logic                                     select_pulse,
    output logic [$clog2(COLS*ROWS+1)-1:0]           select_index
);

    localparam int CW   = $clog2(COLS);
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int IW   = $clog2(COLS*ROWS+1);
    localparam int DBW  = $clog2(DB_CYCLES+1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPW  = $clog2(RMAX+1);

    // Button bit order: 0=left 1=right 2=up 3=down 4=centre
    logic [4:0] btn_raw;
    assign btn_raw = {btn_c, btn_d, btn_u, btn_r, btn_l};

    logic [4:0]     sync1_q, sync2_q;
    logic [4:0]     db_q, db_d, dbp_q;
    logic [DBW-1:0] dbc_q [5];
    logic [DBW-1:0] dbc_d [5];
    logic [RPW-1:0] rc_q [4];
    logic [RPW-1:0] rc_d [4];
    logic [3:0]     rfirst_q, rfirst_d;
    logic [3:0]     rpt;
    logic [4:0]     press;
    logic [4:0]     ev_q, ev_d;
    logic [RPW-1:0] lim;

    logic [CW-1:0]  col_q, col_d;
    logic [RW-1:0]  row_q, row_d;
    logic           moved_q, moved_d;
    logic           sel_q, sel_d;
    logic [IW-1:0]  seli_q, seli_d;

    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 5; i++) begin
            dbc_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (dbc_q[i] == DBW'(DB_CYCLES-1)) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    dbc_d[i] = dbc_q[i] + DBW'(1);
                end
            end
        end
    end

    assign press = db_q & ~dbp_q;

    // Repeat counter runs from the press cycle; the first interval is REPEAT_DELAY, then REPEAT_PERIOD.
    always_comb begin
        rpt      = '0;
        rfirst_d = rfirst_q;
        lim      = '0;
        for (int i = 0; i < 4; i++) begin
            rc_d[i]     = '0;
            rfirst_d[i] = 1'b1;
            if (db_q[i]) begin
                lim = rfirst_q[i] ? RPW'(REPEAT_DELAY) : RPW'(REPEAT_PERIOD);
                if ((REPEAT_DELAY > 0) && (rc_q[i] == lim)) begin
                    rpt[i]      = 1'b1;
                    rc_d[i]     = RPW'(1);
                    rfirst_d[i] = 1'b0;
                end else begin
                    rc_d[i]     = rc_q[i] + RPW'(1);
                    rfirst_d[i] = rfirst_q[i];
                end
            end
        end
    end

    assign ev_d = {press[4], press[3:0] | rpt};

    assign cursor_index = IW'(int'(row_q) * COLS + int'(col_q) + 1);

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        sel_d  = 1'b0;
        seli_d = seli_q;
        if (ev_q[0]) begin
            col_d = (col_q == '0) ? CW'(COLS-1) : col_q - CW'(1);
        end else if (ev_q[1]) begin
            col_d = (col_q == CW'(COLS-1)) ? '0 : col_q + CW'(1);
        end else if (ev_q[2]) begin
            if (row_q == '0) begin
                row_d = (VWRAP != 0) ? RW'(ROWS-1) : row_q;
            end else begin
                row_d = row_q - RW'(1);
            end
        end else if (ev_q[3]) begin
            if (row_q == RW'(ROWS-1)) begin
                row_d = (VWRAP != 0) ? '0 : row_q;
            end else begin
                row_d = row_q + RW'(1);
            end
        end
        moved_d = (col_d != col_q) || (row_d != row_q);
        // Select captures the index as it stood before any coincident move.
        if (ev_q[4]) begin
            sel_d  = 1'b1;
            seli_d = cursor_index;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            db_q     <= '0;
            dbp_q    <= '0;
            ev_q     <= '0;
            rfirst_q <= '1;
            for (int i = 0; i < 5; i++) dbc_q[i] <= '0;
            for (int i = 0; i < 4; i++) rc_q[i] <= '0;
            col_q    <= '0;
            row_q    <= '0;
            moved_q  <= 1'b0;
            sel_q    <= 1'b0;
            seli_q   <= IW'(1);
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            dbp_q    <= db_q;
            ev_q     <= ev_d;
            rfirst_q <= rfirst_d;
            for (int i = 0; i < 5; i++) dbc_q[i] <= dbc_d[i];
            for (int i = 0; i < 4; i++) rc_q[i] <= rc_d[i];
            col_q    <= col_d;
            row_q    <= row_d;
            moved_q  <= moved_d;
            sel_q    <= sel_d;
            seli_q   <= seli_d;
        end
    end

    assign cursor_col   = col_q;
    assign cursor_row   = row_q;
    assign moved        = moved_q;
    assign select_pulse = sel_q;
    assign select_index = seli_q;

endmodule
